// File: rtl/cdb_egress_multi_channel.sv
// Multi-channel CHI egress stage for the DSU CDB.
// Per channel: flit FIFO, one-flit holding register, link credit counter.
module cdb_egress_multi_channel #(
    parameter int NUM_CH     = 4,
    parameter int FLIT_WIDTH = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int CRD_MAX    = 15,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk_out,
    input  logic                         rst_out,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic [NUM_CH*FLIT_WIDTH-1:0] in_flit,
    input  logic                         en_flitv,
    input  logic                         link_deactive,
    input  logic [NUM_CH-1:0]            txcrdv,
    output logic [NUM_CH-1:0]            tx_flitpend,
    output logic [NUM_CH-1:0]            tx_flitv,
    output logic [NUM_CH*FLIT_WIDTH-1:0] tx_flit,
    output logic [NUM_CH*CNT_W-1:0]      fifo_cnt,
    output logic [NUM_CH-1:0]            crd_err,
    output logic                         deact_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CRD_W = $clog2(CRD_MAX + 1);

    logic [NUM_CH-1:0] crd_zero;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [FLIT_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]      wr_ptr;
        logic [PTR_W-1:0]      rd_ptr;
        logic [CNT_W-1:0]      cnt;
        logic                  hold_v;
        logic [FLIT_WIDTH-1:0] hold_flit;
        logic [CRD_W-1:0]      crd;
        logic                  err;
        logic                  full;
        logic                  push;
        logic                  pop;
        logic                  crd_avail;
        logic                  send;
        logic                  lret;
        logic                  flitv;

        assign full      = (cnt == CNT_W'(FIFO_DEPTH));
        assign push      = in_valid[c] & ~full;
        assign crd_avail = (crd != '0);
        assign send      = hold_v & crd_avail & en_flitv & ~link_deactive;
        assign pop       = (cnt != '0) & (~hold_v | send);
        assign lret      = link_deactive & crd_avail;
        assign flitv     = send | lret;

        always_ff @(posedge clk_out) begin
            if (rst_out) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)
                    cnt <= cnt + CNT_W'(1);
                else if (pop && !push)
                    cnt <= cnt - CNT_W'(1);
            end
        end

        // Storage needs no reset: pointers and count define validity.
        always_ff @(posedge clk_out) begin
            if (push)
                mem[wr_ptr] <= in_flit[c*FLIT_WIDTH +: FLIT_WIDTH];
        end

        always_ff @(posedge clk_out) begin
            if (rst_out) begin
                hold_v    <= 1'b0;
                hold_flit <= '0;
            end else if (pop) begin
                hold_v    <= 1'b1;
                hold_flit <= mem[rd_ptr];
            end else if (send) begin
                hold_v    <= 1'b0;
            end
        end

        always_ff @(posedge clk_out) begin
            if (rst_out) begin
                crd <= '0;
                err <= 1'b0;
            end else if (txcrdv[c] && !flitv) begin
                if (crd == CRD_W'(CRD_MAX))
                    err <= 1'b1;
                else
                    crd <= crd + CRD_W'(1);
            end else if (flitv && !txcrdv[c]) begin
                crd <= crd - CRD_W'(1);
            end
        end

        assign in_ready[c]    = ~full;
        assign tx_flitpend[c] = hold_v | (cnt != '0);
        assign tx_flitv[c]    = flitv;
        assign tx_flit[c*FLIT_WIDTH +: FLIT_WIDTH] = send ? hold_flit : '0;
        assign fifo_cnt[c*CNT_W +: CNT_W] = cnt;
        assign crd_err[c]     = err;
        assign crd_zero[c]    = ~crd_avail;
    end

    assign deact_done = link_deactive & (&crd_zero);

endmodule

// File: tb/tb_cdb_egress_multi_channel.sv
// Directed bench for cdb_egress_multi_channel.
// Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_cdb_egress_multi_channel;

    localparam int NCH = 4;
    localparam int FW  = 64;
    localparam int CW  = 4;

    logic            clk_out = 1'b0;
    logic            rst_out;
    logic [NCH-1:0]  in_valid;
    logic [NCH-1:0]  in_ready;
    logic [NCH*FW-1:0] in_flit;
    logic            en_flitv;
    logic            link_deactive;
    logic [NCH-1:0]  txcrdv;
    logic [NCH-1:0]  tx_flitpend;
    logic [NCH-1:0]  tx_flitv;
    logic [NCH*FW-1:0] tx_flit;
    logic [NCH*CW-1:0] fifo_cnt;
    logic [NCH-1:0]  crd_err;
    logic            deact_done;

    int total = 0;
    int bad   = 0;

    cdb_egress_multi_channel dut (
        .clk_out       (clk_out),
        .rst_out       (rst_out),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_flit       (in_flit),
        .en_flitv      (en_flitv),
        .link_deactive (link_deactive),
        .txcrdv        (txcrdv),
        .tx_flitpend   (tx_flitpend),
        .tx_flitv      (tx_flitv),
        .tx_flit       (tx_flit),
        .fifo_cnt      (fifo_cnt),
        .crd_err       (crd_err),
        .deact_done    (deact_done)
    );

    always #5 clk_out = ~clk_out;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    task automatic neg();
        @(negedge clk_out);
    endtask

    function automatic logic [63:0] txf(input int c);
        return tx_flit[c*FW +: FW];
    endfunction

    function automatic logic [63:0] fcnt(input int c);
        return 64'(fifo_cnt[c*CW +: CW]);
    endfunction

    task automatic credits(input int c, input int n);
        txcrdv[c] = 1'b1;
        repeat (n) tick();
        txcrdv[c] = 1'b0;
    endtask

    initial begin
        int n;
        rst_out       = 1'b1;
        in_valid      = '0;
        in_flit       = '0;
        en_flitv      = 1'b0;
        link_deactive = 1'b0;
        txcrdv        = '0;
        tick();
        tick();
        neg();
        check("rst_in_ready", 64'(in_ready), 64'hF);
        check("rst_flitv", 64'(tx_flitv), 64'h0);
        check("rst_pend", 64'(tx_flitpend), 64'h0);
        check("rst_crd_err", 64'(crd_err), 64'h0);
        check("rst_deact", 64'(deact_done), 64'h0);
        check("rst_flit", 64'(|tx_flit), 64'h0);
        check("rst_cnt", 64'(fifo_cnt), 64'h0);
        tick();
        rst_out = 1'b0;

        // basic send on ch0
        credits(0, 2);
        en_flitv = 1'b1;
        in_valid[0] = 1'b1;
        in_flit[0*FW +: FW] = 64'hA1;
        tick();
        in_flit[0*FW +: FW] = 64'hA2;
        neg();
        check("bs_nolaunch_t1", 64'(tx_flitv[0]), 64'h0);
        tick();
        in_valid[0] = 1'b0;
        neg();
        check("bs_v1", 64'(tx_flitv[0]), 64'h1);
        check("bs_d1", txf(0), 64'hA1);
        tick();
        neg();
        check("bs_v2", 64'(tx_flitv[0]), 64'h1);
        check("bs_d2", txf(0), 64'hA2);
        tick();
        neg();
        check("bs_v3", 64'(tx_flitv[0]), 64'h0);
        check("bs_pend", 64'(tx_flitpend[0]), 64'h0);
        link_deactive = 1'b1;
        #1;
        check("bs_crd0", 64'(deact_done), 64'h1);
        link_deactive = 1'b0;
        tick();

        // no-credit stall on ch1
        in_valid[1] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_flit[1*FW +: FW] = 64'h100 + 64'(i);
            tick();
        end
        in_valid[1] = 1'b0;
        neg();
        check("st_ready", 64'(in_ready[1]), 64'h0);
        check("st_cnt", fcnt(1), 64'd8);
        check("st_flitv", 64'(tx_flitv[1]), 64'h0);
        check("st_pend", 64'(tx_flitpend[1]), 64'h1);
        tick();
        credits(1, 1);
        neg();
        check("st_send_v", 64'(tx_flitv[1]), 64'h1);
        check("st_send_d", txf(1), 64'h100);
        tick();
        neg();
        check("st_one_only", 64'(tx_flitv[1]), 64'h0);
        check("st_ready2", 64'(in_ready[1]), 64'h1);
        check("st_cnt2", fcnt(1), 64'd7);

        // simultaneous credit in/out on ch1
        tick();
        credits(1, 1);
        txcrdv[1] = 1'b1;
        neg();
        check("sim_v1", 64'(tx_flitv[1]), 64'h1);
        check("sim_d1", txf(1), 64'h101);
        tick();
        neg();
        check("sim_v2", 64'(tx_flitv[1]), 64'h1);
        check("sim_d2", txf(1), 64'h102);
        tick();
        txcrdv[1] = 1'b0;
        neg();
        check("sim_v3", 64'(tx_flitv[1]), 64'h1);
        check("sim_d3", txf(1), 64'h103);
        tick();
        neg();
        check("sim_end", 64'(tx_flitv[1]), 64'h0);
        check("sim_cnt", fcnt(1), 64'd4);

        // credit overflow on ch3
        en_flitv = 1'b0;
        tick();
        credits(3, 15);
        neg();
        check("ovf_none", 64'(crd_err[3]), 64'h0);
        tick();
        credits(3, 1);
        neg();
        check("ovf_set", 64'(crd_err[3]), 64'h1);
        tick();
        tick();
        neg();
        check("ovf_sticky", 64'(crd_err), 64'h8);
        tick();
        link_deactive = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            neg();
            if (!tx_flitv[3])
                break;
            n++;
            tick();
        end
        check("ovf_crd15", 64'(n), 64'd15);
        check("ovf_deact", 64'(deact_done), 64'h1);
        tick();
        link_deactive = 1'b0;

        // deactivation on ch2
        credits(2, 3);
        in_valid[2] = 1'b1;
        in_flit[2*FW +: FW] = 64'hC1;
        tick();
        in_flit[2*FW +: FW] = 64'hC2;
        tick();
        in_valid[2] = 1'b0;
        en_flitv = 1'b1;
        link_deactive = 1'b1;
        for (int i = 0; i < 3; i++) begin
            neg();
            check("dea_v", 64'(tx_flitv[2]), 64'h1);
            check("dea_zero", txf(2), 64'h0);
            check("dea_busy", 64'(deact_done), 64'h0);
            tick();
        end
        neg();
        check("dea_stop", 64'(tx_flitv[2]), 64'h0);
        check("dea_done", 64'(deact_done), 64'h1);
        check("dea_pend", 64'(tx_flitpend[2]), 64'h1);
        check("dea_cnt", fcnt(2), 64'd1);
        tick();
        link_deactive = 1'b0;
        neg();
        check("dea_nocrd", 64'(tx_flitv[2]), 64'h0);
        tick();
        credits(2, 1);
        neg();
        check("dea_kept_v", 64'(tx_flitv[2]), 64'h1);
        check("dea_kept_d", txf(2), 64'hC1);
        tick();

        // mid-operation reset
        en_flitv = 1'b0;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_flit[0*FW +: FW] = 64'h200 + 64'(i);
            tick();
        end
        in_valid[0] = 1'b0;
        credits(3, 2);
        neg();
        check("mr_pre_cnt", fcnt(0), 64'd4);
        tick();
        rst_out = 1'b1;
        tick();
        neg();
        check("mr_ready", 64'(in_ready), 64'hF);
        check("mr_cnt", 64'(fifo_cnt), 64'h0);
        check("mr_pend", 64'(tx_flitpend), 64'h0);
        check("mr_err", 64'(crd_err), 64'h0);
        check("mr_flitv", 64'(tx_flitv), 64'h0);
        tick();
        rst_out = 1'b0;
        en_flitv = 1'b1;
        link_deactive = 1'b1;
        neg();
        check("mr_crd_gone", 64'(tx_flitv), 64'h0);
        check("mr_deact", 64'(deact_done), 64'h1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
